// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for a simple in-order core. A five-state FSM
// (IDLE, FETCH, EXEC, HALT, FAULT) issues instruction-fetch requests, waits
// for the fetched word, then waits for the datapath to finish the instruction
// before selecting the next pc (jump, taken branch or sequential stride).
//
// Optional feature (compile-time macro PC_ALIGN_CHECK_EN):
//   When defined, a redirect target that is not 4-byte aligned sends the FSM
//   to FAULT at the completion cycle; pc and retired are left untouched and
//   only reset leaves FAULT. When undefined, FAULT is unreachable and fault
//   is tied low.
//
// Handshakes:
//   imem_req is a level request held for the whole FETCH state; the cycle on
//   which imem_ack is sampled high at a rising edge accepts the word and ends
//   FETCH. imem_ack seen in any other state is ignored. An instruction
//   completes on the first EXEC cycle with exec_done=1 and stall=0.
//
// Parameters:
//   RESET_PC      pc value loaded on reset
//   PC_INCR       sequential fetch stride in bytes
//
// Ports:
//   clk           clock, all state changes on rising edge
//   rst           asynchronous active-low reset
//   start         begin/resume sequencing (honoured in IDLE and HALT only)
//   imem_req      fetch request, high only in FETCH
//   imem_ack      fetch completion from instruction memory
//   instr_valid   one-cycle pulse on the first cycle of each EXEC visit
//   exec_done     datapath finished the current instruction
//   stall         hazard hold, blocks completion
//   jump          unconditional redirect to jump_target
//   jump_target   jump destination
//   branch_taken  taken conditional branch to branch_target
//   branch_target branch destination
//   halt          current instruction is a halt
//   pc            current program counter
//   state         FSM encoding (IDLE=0 FETCH=1 EXEC=2 HALT=3 FAULT=4)
//   retired       number of completed instructions (wraps)
//   fault         high only while in FAULT
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_INCR  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        jump,
  input  logic [63:0] jump_target,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        halt,
  output logic [63:0] pc,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        exec_first_q, exec_first_d;

  // Completion and next-pc selection. Jump has priority over branch.
  logic        complete;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [63:0] seq_pc;
  logic        misaligned;

  assign complete        = (state_q == S_EXEC) && exec_done && !stall;
  assign redirect        = jump || branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;
  assign seq_pc          = pc_q + 64'(PC_INCR);

`ifdef PC_ALIGN_CHECK_EN
  // Only a selected redirect target is checked; the sequential path keeps
  // whatever alignment RESET_PC and PC_INCR give it.
  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      retired_q    <= 32'd0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
      exec_first_q <= exec_first_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retired_d    = retired_q;
    exec_first_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack) begin
          state_d      = S_EXEC;
          exec_first_d = 1'b1;
        end
      end

      S_EXEC: begin
        if (complete) begin
          if (misaligned) begin
            // Faulting instruction does not retire and pc stays on it.
            state_d = S_FAULT;
          end else begin
            pc_d      = redirect ? redirect_target : seq_pc;
            retired_d = retired_q + 32'd1;
            state_d   = halt ? S_HALT : S_FETCH;
          end
        end
      end

      S_HALT: begin
        if (start) state_d = S_FETCH;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs (all Moore / registered)
  assign imem_req    = (state_q == S_FETCH);
  // exec_first_q is only ever set on the FETCH->EXEC edge, so it marks the
  // first EXEC cycle and drops on the next one.
  assign instr_valid = exec_first_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign retired     = retired_q;

`ifdef PC_ALIGN_CHECK_EN
  assign fault = (state_q == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer. Inputs change right after the falling
// edge; outputs are checked on the falling edge, half a period after the
// rising edge that updated them. Build with +define+PC_ALIGN_CHECK_EN to
// check the alignment-fault variant.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic        imem_ack;
  logic        instr_valid;
  logic        exec_done;
  logic        stall;
  logic        jump;
  logic [63:0] jump_target;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        halt;
  logic [63:0] pc;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        fault;

  int errors;
  int checks;

  pc_sequencer #(
    .RESET_PC (64'h0),
    .PC_INCR  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .pc            (pc),
    .state         (state),
    .retired       (retired),
    .fault         (fault)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic clear_inputs();
    start         = 1'b0;
    imem_ack      = 1'b0;
    exec_done     = 1'b0;
    stall         = 1'b0;
    jump          = 1'b0;
    jump_target   = 64'h0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    halt          = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fetch_ack();
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic complete(input logic j, input logic [63:0] jt,
                          input logic b, input logic [63:0] bt,
                          input logic h);
    exec_done     = 1'b1;
    jump          = j;
    jump_target   = jt;
    branch_taken  = b;
    branch_target = bt;
    halt          = h;
    @(negedge clk);
    clear_inputs();
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: req=%b iv=%b fault=%b want 0 0 0", imem_req, instr_valid, fault);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (state !== 3'd0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_hold: state=%0d req=%b want 0 0", state, imem_req);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc;
    exp_pc = 64'h0;
    start_run();
    checks++; if (state !== 3'd1 || imem_req !== 1'b1) begin
      errors++; $display("FAIL seq_start: state=%0d req=%b want 1 1", state, imem_req);
    end
    // Memory slow by one extra cycle: FETCH must wait.
    @(negedge clk);
    checks++; if (state !== 3'd1 || pc !== 64'h0) begin
      errors++; $display("FAIL seq_wait_ack: state=%0d pc=%h want 1 0", state, pc);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc !== exp_pc || imem_req !== 1'b1) begin
        errors++; $display("FAIL seq_fetch%0d: pc=%h req=%b want %h 1", i, pc, imem_req, exp_pc);
      end
      fetch_ack();
      checks++; if (state !== 3'd2 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        errors++; $display("FAIL seq_exec%0d: state=%0d iv=%b req=%b want 2 1 0", i, state, instr_valid, imem_req);
      end
      complete(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      exp_pc = exp_pc + 64'd4;
      checks++; if (state !== 3'd1 || instr_valid !== 1'b0 || pc !== exp_pc) begin
        errors++; $display("FAIL seq_done%0d: state=%0d iv=%b pc=%h want 1 0 %h", i, state, instr_valid, pc, exp_pc);
      end
    end
    checks++; if (pc !== 64'd12 || retired !== 32'd3) begin
      errors++; $display("FAIL seq_final: pc=%h retired=%0d want c 3", pc, retired);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    start_run();
    fetch_ack();
    complete(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    fetch_ack();
    complete(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    fetch_ack();
    checks++; if (pc !== 64'd8 || state !== 3'd2) begin
      errors++; $display("FAIL redir_setup: pc=%h state=%0d want 8 2", pc, state);
    end
    complete(1'b1, 64'h100, 1'b1, 64'h200, 1'b0);
    checks++; if (pc !== 64'h100 || state !== 3'd1 || retired !== 32'd3) begin
      errors++; $display("FAIL redir_priority: pc=%h state=%0d retired=%0d want 100 1 3", pc, state, retired);
    end
  endtask

  task automatic test_stall();
    // Redirect/halt/done presented during FETCH must be ignored.
    jump = 1'b1; jump_target = 64'h500; halt = 1'b1; exec_done = 1'b1; start = 1'b1;
    @(negedge clk);
    clear_inputs();
    checks++; if (state !== 3'd1 || pc !== 64'h100 || retired !== 32'd3) begin
      errors++; $display("FAIL fetch_ignores: state=%0d pc=%h retired=%0d want 1 100 3", state, pc, retired);
    end
    fetch_ack();
    exec_done = 1'b1;
    stall     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (state !== 3'd2 || pc !== 64'h100 || instr_valid !== 1'b0 || retired !== 32'd3) begin
        errors++; $display("FAIL stall_hold%0d: state=%0d pc=%h iv=%b retired=%0d want 2 100 0 3",
                           i, state, pc, instr_valid, retired);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    clear_inputs();
    checks++; if (state !== 3'd1 || pc !== 64'h104 || retired !== 32'd4) begin
      errors++; $display("FAIL stall_release: state=%0d pc=%h retired=%0d want 1 104 4", state, pc, retired);
    end
    @(negedge clk);
    checks++; if (pc !== 64'h104 || retired !== 32'd4) begin
      errors++; $display("FAIL stall_single: pc=%h retired=%0d want 104 4", pc, retired);
    end
  endtask

  task automatic test_halt();
    fetch_ack();
    complete(1'b0, 64'h0, 1'b1, 64'h40, 1'b1);
    checks++; if (state !== 3'd3 || pc !== 64'h40 || retired !== 32'd5 || imem_req !== 1'b0) begin
      errors++; $display("FAIL halt_enter: state=%0d pc=%h retired=%0d req=%b want 3 40 5 0",
                         state, pc, retired, imem_req);
    end
    imem_ack = 1'b1; exec_done = 1'b1; jump = 1'b1; jump_target = 64'h800;
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    checks++; if (state !== 3'd3 || pc !== 64'h40 || retired !== 32'd5) begin
      errors++; $display("FAIL halt_hold: state=%0d pc=%h retired=%0d want 3 40 5", state, pc, retired);
    end
    start_run();
    checks++; if (state !== 3'd1 || imem_req !== 1'b1 || pc !== 64'h40) begin
      errors++; $display("FAIL halt_resume: state=%0d req=%b pc=%h want 1 1 40", state, imem_req, pc);
    end
  endtask

  task automatic test_async_reset();
    // Mid-FETCH, between edges.
    #2;
    rst = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || pc !== 64'h0 || imem_req !== 1'b0 || retired !== 32'd0) begin
      errors++; $display("FAIL async_reset: state=%0d pc=%h req=%b retired=%0d want 0 0 0 0",
                         state, pc, imem_req, retired);
    end
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (state !== 3'd0 || imem_req !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle%0d: state=%0d req=%b want 0 0", i, state, imem_req);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    start_run();
    fetch_ack();
    complete(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0);
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_jump: pc=%h want fffffffffffffffc", pc);
    end
    fetch_ack();
    complete(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    checks++; if (pc !== 64'h0 || retired !== 32'd2 || state !== 3'd1) begin
      errors++; $display("FAIL wrap_pc: pc=%h retired=%0d state=%0d want 0 2 1", pc, retired, state);
    end
  endtask

  task automatic test_align();
    fetch_ack();
    complete(1'b1, 64'h102, 1'b0, 64'h0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (state !== 3'd4 || fault !== 1'b1 || pc !== 64'h0 || retired !== 32'd2) begin
      errors++; $display("FAIL align_fault: state=%0d fault=%b pc=%h retired=%0d want 4 1 0 2",
                         state, fault, pc, retired);
    end
    start_run();
    checks++; if (state !== 3'd4 || fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL align_sticky: state=%0d fault=%b req=%b want 4 1 0", state, fault, imem_req);
    end
`else
    checks++; if (state !== 3'd1 || fault !== 1'b0 || pc !== 64'h102 || retired !== 32'd3) begin
      errors++; $display("FAIL align_none: state=%0d fault=%b pc=%h retired=%0d want 1 0 102 3",
                         state, fault, pc, retired);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_halt();
    test_async_reset();
    test_wrap();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
